// File: rtl/bcd_countdown_timer.sv
// Loadable MM:SS BCD countdown timer with internal one-second prescaler and active-low 7-segment outputs.
// Digits, segments and status flags are all registered; a decrement lands TICK_DIV cycles after RUN begins.
module bcd_countdown_timer #(
    parameter int TICK_DIV = 50000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       load,
    input  logic [3:0] ld_m1,
    input  logic [3:0] ld_m0,
    input  logic [3:0] ld_s1,
    input  logic [3:0] ld_s0,
    input  logic       start,
    input  logic       pause,
    input  logic       clear,
    output logic [3:0] m1,
    output logic [3:0] m0,
    output logic [3:0] s1,
    output logic [3:0] s0,
    output logic [6:0] hex3,
    output logic [6:0] hex2,
    output logic [6:0] hex1,
    output logic [6:0] hex0,
    output logic       running,
    output logic       done,
    output logic       expired,
    output logic       load_err
);

    localparam int PW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] TICK_LAST = PW'(TICK_DIV - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSE, S_DONE} state_t;

    state_t        r_state;
    logic [PW-1:0] r_presc;

    logic       w_zero, w_ld_valid, w_load_act, w_load_ok, w_load_bad;
    logic       w_run_cmd, w_tick, w_start, w_dec_zero;
    logic [3:0] w_dm1, w_dm0, w_ds1, w_ds0;
    logic [3:0] w_nm1, w_nm0, w_ns1, w_ns0;

    function automatic logic [6:0] seg7(input logic [3:0] d);
        case (d)
            4'd0:    seg7 = 7'b1000000;
            4'd1:    seg7 = 7'b1111001;
            4'd2:    seg7 = 7'b0100100;
            4'd3:    seg7 = 7'b0110000;
            4'd4:    seg7 = 7'b0011001;
            4'd5:    seg7 = 7'b0010010;
            4'd6:    seg7 = 7'b0000010;
            4'd7:    seg7 = 7'b1111000;
            4'd8:    seg7 = 7'b0000000;
            4'd9:    seg7 = 7'b0011000;
            default: seg7 = 7'b1111111;
        endcase
    endfunction

    // Command decode, highest priority first: clear, load (not in RUN), pause, start.
    assign w_zero     = ({m1, m0, s1, s0} == 16'h0000);
    assign w_ld_valid = (ld_m1 <= 4'd5) && (ld_m0 <= 4'd9) && (ld_s1 <= 4'd5) && (ld_s0 <= 4'd9);
    assign w_load_act = load && !clear && (r_state != S_RUN);
    assign w_load_ok  = w_load_act && w_ld_valid;
    assign w_load_bad = w_load_act && !w_ld_valid;
    assign w_run_cmd  = !clear && (r_state == S_RUN);
    assign w_tick     = w_run_cmd && !pause && (r_presc == TICK_LAST) && !w_zero;
    assign w_start    = !clear && !w_load_act && !pause && start && !w_zero &&
                        ((r_state == S_IDLE) || (r_state == S_PAUSE));
    assign w_dec_zero = ({w_dm1, w_dm0, w_ds1, w_ds0} == 16'h0000);

    always_comb begin
        w_dm1 = m1;
        w_dm0 = m0;
        w_ds1 = s1;
        w_ds0 = s0;
        if (s0 != 4'd0) begin
            w_ds0 = s0 - 4'd1;
        end else begin
            w_ds0 = 4'd9;
            if (s1 != 4'd0) begin
                w_ds1 = s1 - 4'd1;
            end else begin
                w_ds1 = 4'd5;
                if (m0 != 4'd0) begin
                    w_dm0 = m0 - 4'd1;
                end else begin
                    w_dm0 = 4'd9;
                    w_dm1 = m1 - 4'd1;
                end
            end
        end
    end

    always_comb begin
        w_nm1 = m1;
        w_nm0 = m0;
        w_ns1 = s1;
        w_ns0 = s0;
        if (clear) begin
            w_nm1 = 4'd0;
            w_nm0 = 4'd0;
            w_ns1 = 4'd0;
            w_ns0 = 4'd0;
        end else if (w_load_ok) begin
            w_nm1 = ld_m1;
            w_nm0 = ld_m0;
            w_ns1 = ld_s1;
            w_ns0 = ld_s0;
        end else if (w_tick) begin
            w_nm1 = w_dm1;
            w_nm0 = w_dm0;
            w_ns1 = w_ds1;
            w_ns0 = w_ds0;
        end
    end

    // Segments are encoded from the next digit values so they change on the same edge as the digits.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            m1   <= 4'd0;
            m0   <= 4'd0;
            s1   <= 4'd0;
            s0   <= 4'd0;
            hex3 <= 7'b1000000;
            hex2 <= 7'b1000000;
            hex1 <= 7'b1000000;
            hex0 <= 7'b1000000;
        end else begin
            m1   <= w_nm1;
            m0   <= w_nm0;
            s1   <= w_ns1;
            s0   <= w_ns0;
            hex3 <= seg7(w_nm1);
            hex2 <= seg7(w_nm0);
            hex1 <= seg7(w_ns1);
            hex0 <= seg7(w_ns0);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_presc  <= '0;
            running  <= 1'b0;
            done     <= 1'b0;
            expired  <= 1'b0;
            load_err <= 1'b0;
        end else begin
            expired  <= 1'b0;
            load_err <= w_load_bad;
            if (clear || w_load_ok) begin
                r_state <= S_IDLE;
                r_presc <= '0;
                running <= 1'b0;
                done    <= 1'b0;
            end else if (!w_load_act) begin
                case (r_state)
                    S_IDLE: begin
                        if (w_start) begin
                            r_state <= S_RUN;
                            r_presc <= '0;
                            running <= 1'b1;
                        end
                    end
                    S_PAUSE: begin
                        if (w_start) begin
                            r_state <= S_RUN;
                            running <= 1'b1;
                        end
                    end
                    S_RUN: begin
                        if (pause) begin
                            r_state <= S_PAUSE;
                            running <= 1'b0;
                        end else if (r_presc == TICK_LAST) begin
                            r_presc <= '0;
                            if (w_tick && w_dec_zero) begin
                                r_state <= S_DONE;
                                running <= 1'b0;
                                done    <= 1'b1;
                                expired <= 1'b1;
                            end
                        end else begin
                            r_presc <= r_presc + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// Table-driven bench for bcd_countdown_timer with TICK_DIV=4; expectations queued per vector, checked after its cycles.
module tb_bcd_countdown_timer;

    logic       clk = 1'b0;
    logic       rst;
    logic       load, start, pause, clear;
    logic [3:0] ld_m1, ld_m0, ld_s1, ld_s0;
    logic [3:0] m1, m0, s1, s0;
    logic [6:0] hex3, hex2, hex1, hex0;
    logic       running, done, expired, load_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    bcd_countdown_timer #(.TICK_DIV(4)) dut (
        .clk(clk), .rst(rst), .load(load),
        .ld_m1(ld_m1), .ld_m0(ld_m0), .ld_s1(ld_s1), .ld_s0(ld_s0),
        .start(start), .pause(pause), .clear(clear),
        .m1(m1), .m0(m0), .s1(s1), .s0(s0),
        .hex3(hex3), .hex2(hex2), .hex1(hex1), .hex0(hex0),
        .running(running), .done(done), .expired(expired), .load_err(load_err)
    );

    typedef struct {
        string       name;
        logic        ld;
        logic [15:0] ldv;
        logic        st, pa, cl;
        int          idle;
        logic [15:0] ed;
        logic        er, edn, eex, ele;
    } vec_t;

    typedef struct {
        string       name;
        logic [15:0] d;
        logic        r, dn, ex, le;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];

    function automatic logic [6:0] seg_ref(input logic [3:0] d);
        case (d)
            4'd0: seg_ref = 7'b1000000;
            4'd1: seg_ref = 7'b1111001;
            4'd2: seg_ref = 7'b0100100;
            4'd3: seg_ref = 7'b0110000;
            4'd4: seg_ref = 7'b0011001;
            4'd5: seg_ref = 7'b0010010;
            4'd6: seg_ref = 7'b0000010;
            4'd7: seg_ref = 7'b1111000;
            4'd8: seg_ref = 7'b0000000;
            4'd9: seg_ref = 7'b0011000;
            default: seg_ref = 7'b1111111;
        endcase
    endfunction

    function automatic vec_t mk(string name, logic ld, logic [15:0] ldv, logic st, logic pa,
                                logic cl, int idle, logic [15:0] ed, logic er, logic edn,
                                logic eex, logic ele);
        vec_t v;
        v.name = name; v.ld = ld; v.ldv = ldv; v.st = st; v.pa = pa; v.cl = cl;
        v.idle = idle; v.ed = ed; v.er = er; v.edn = edn; v.eex = eex; v.ele = ele;
        return v;
    endfunction

    task automatic check(input exp_t e);
        logic [27:0] hex_exp;
        hex_exp = {seg_ref(e.d[15:12]), seg_ref(e.d[11:8]), seg_ref(e.d[7:4]), seg_ref(e.d[3:0])};
        n_checks++;
        if ({m1, m0, s1, s0} !== e.d) begin
            n_fail++;
            $display("FAIL %s digits: got %h expected %h", e.name, {m1, m0, s1, s0}, e.d);
        end
        n_checks++;
        if ({hex3, hex2, hex1, hex0} !== hex_exp) begin
            n_fail++;
            $display("FAIL %s hex: got %b expected %b", e.name, {hex3, hex2, hex1, hex0}, hex_exp);
        end
        n_checks++;
        if ({running, done, expired, load_err} !== {e.r, e.dn, e.ex, e.le}) begin
            n_fail++;
            $display("FAIL %s flags(run,done,exp,lerr): got %b expected %b", e.name,
                     {running, done, expired, load_err}, {e.r, e.dn, e.ex, e.le});
        end
    endtask

    task automatic idle_inputs();
        load = 0; start = 0; pause = 0; clear = 0;
        ld_m1 = 0; ld_m0 = 0; ld_s1 = 0; ld_s0 = 0;
    endtask

    // Called at a negedge: drive the command for one edge, then idle for v.idle edges, then compare.
    task automatic run_vec(input vec_t v);
        exp_t e;
        e.name = v.name; e.d = v.ed; e.r = v.er; e.dn = v.edn; e.ex = v.eex; e.le = v.ele;
        sb.push_back(e);
        load = v.ld; start = v.st; pause = v.pa; clear = v.cl;
        {ld_m1, ld_m0, ld_s1, ld_s0} = v.ldv;
        @(negedge clk);
        idle_inputs();
        repeat (v.idle) @(negedge clk);
        check(sb.pop_front());
    endtask

    initial begin
        exp_t e0;
        e0.name = "reset"; e0.d = 16'h0000; e0.r = 0; e0.dn = 0; e0.ex = 0; e0.le = 0;

        vecs.push_back(mk("load 10:00",          1, 16'h1000, 0, 0, 0, 0,  16'h1000, 0, 0, 0, 0));
        vecs.push_back(mk("run pre-tick",        0, 16'h0000, 1, 0, 0, 3,  16'h1000, 1, 0, 0, 0));
        vecs.push_back(mk("tick 09:59",          0, 16'h0000, 0, 0, 0, 0,  16'h0959, 1, 0, 0, 0));
        vecs.push_back(mk("tick 09:58",          0, 16'h0000, 0, 0, 0, 3,  16'h0958, 1, 0, 0, 0));
        vecs.push_back(mk("load in RUN ignored", 1, 16'h0001, 0, 0, 0, 0,  16'h0958, 1, 0, 0, 0));
        vecs.push_back(mk("clear beats load",    1, 16'h1234, 0, 0, 1, 0,  16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk("start at 00:00",      0, 16'h0000, 1, 0, 0, 2,  16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk("load 00:02",          1, 16'h0002, 0, 0, 0, 0,  16'h0002, 0, 0, 0, 0));
        vecs.push_back(mk("run 00:02",           0, 16'h0000, 1, 0, 0, 3,  16'h0002, 1, 0, 0, 0));
        vecs.push_back(mk("tick 00:01",          0, 16'h0000, 0, 0, 0, 0,  16'h0001, 1, 0, 0, 0));
        vecs.push_back(mk("expiry",              0, 16'h0000, 0, 0, 0, 3,  16'h0000, 0, 1, 1, 0));
        vecs.push_back(mk("after expiry",        0, 16'h0000, 0, 0, 0, 19, 16'h0000, 0, 1, 0, 0));
        vecs.push_back(mk("start in DONE",       0, 16'h0000, 1, 0, 0, 0,  16'h0000, 0, 1, 0, 0));
        vecs.push_back(mk("invalid load 00:70",  1, 16'h0070, 0, 0, 0, 0,  16'h0000, 0, 1, 0, 1));
        vecs.push_back(mk("load_err one cycle",  0, 16'h0000, 0, 0, 0, 0,  16'h0000, 0, 1, 0, 0));
        vecs.push_back(mk("load 00:03",          1, 16'h0003, 0, 0, 0, 0,  16'h0003, 0, 0, 0, 0));
        vecs.push_back(mk("run 00:03",           0, 16'h0000, 1, 0, 0, 2,  16'h0003, 1, 0, 0, 0));
        vecs.push_back(mk("pause hold",          0, 16'h0000, 0, 1, 0, 9,  16'h0003, 0, 0, 0, 0));
        vecs.push_back(mk("resume",              0, 16'h0000, 1, 0, 0, 1,  16'h0003, 1, 0, 0, 0));
        vecs.push_back(mk("tick after resume",   0, 16'h0000, 0, 0, 0, 0,  16'h0002, 1, 0, 0, 0));
        vecs.push_back(mk("expiry after resume", 0, 16'h0000, 0, 0, 0, 7,  16'h0000, 0, 1, 1, 0));
        vecs.push_back(mk("load 00:05",          1, 16'h0005, 0, 0, 0, 0,  16'h0005, 0, 0, 0, 0));
        vecs.push_back(mk("start 00:05",         0, 16'h0000, 1, 0, 0, 0,  16'h0005, 1, 0, 0, 0));
        vecs.push_back(mk("pause+start in RUN",  0, 16'h0000, 1, 1, 0, 0,  16'h0005, 0, 0, 0, 0));
        vecs.push_back(mk("invalid load PAUSE",  1, 16'h000A, 0, 0, 0, 0,  16'h0005, 0, 0, 0, 1));
        vecs.push_back(mk("resume from PAUSE",   0, 16'h0000, 1, 0, 0, 0,  16'h0005, 1, 0, 0, 0));
        vecs.push_back(mk("clear in RUN",        0, 16'h0000, 0, 0, 1, 0,  16'h0000, 0, 0, 0, 0));
        vecs.push_back(mk("load 46:57",          1, 16'h4657, 0, 0, 0, 0,  16'h4657, 0, 0, 0, 0));
        vecs.push_back(mk("invalid m1 60:00",    1, 16'h6000, 0, 0, 0, 0,  16'h4657, 0, 0, 0, 1));
        vecs.push_back(mk("load 59:59",          1, 16'h5959, 0, 0, 0, 0,  16'h5959, 0, 0, 0, 0));
        vecs.push_back(mk("run 59:59",           0, 16'h0000, 1, 0, 0, 3,  16'h5959, 1, 0, 0, 0));
        vecs.push_back(mk("tick 59:58",          0, 16'h0000, 0, 0, 0, 0,  16'h5958, 1, 0, 0, 0));

        idle_inputs();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check(e0);
        rst = 1'b0;
        @(negedge clk);
        e0.name = "post-reset idle";
        check(e0);

        for (int i = 0; i < vecs.size(); i++) run_vec(vecs[i]);

        // Asynchronous reset between edges while counting.
        @(posedge clk);
        #3 rst = 1'b1;
        #1;
        e0.name = "async reset mid-run";
        check(e0);
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        e0.name = "stays idle after reset";
        check(e0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
